// File: rtl/perip_clken_sched.sv
// Periodic single-cycle clock-enable strobes (period div+1 PCLK cycles) for dualtimer ch1/ch2 and watchdog.
// Strobes are flops; config writes land on the sampling edge with no wait states and no backpressure.

module perip_clken_chan #(
  parameter int DIVW = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            div_wr,
  input  logic [DIVW-1:0] div_wdata,
  input  logic            ctrl_wr,
  input  logic            ctrl_bit,
  input  logic            restart,
  output logic [DIVW-1:0] div,
  output logic            en,
  output logic            clken
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [DIVW-1:0] cnt;

  assign en = (state == RUN);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      div   <= '0;
      cnt   <= '0;
      clken <= 1'b0;
    end else begin
      // The reload below samples the pre-write div, so a new divisor waits for the next reload.
      if (div_wr) begin
        div <= div_wdata;
      end
      case (state)
        IDLE: begin
          clken <= 1'b0;
          if (ctrl_wr && ctrl_bit) begin
            state <= RUN;
            cnt   <= div;
          end
        end
        RUN: begin
          if (ctrl_wr && !ctrl_bit) begin
            state <= IDLE;
            clken <= 1'b0;
          end else if (restart) begin
            cnt   <= div;
            clken <= 1'b0;
          end else if (cnt == '0) begin
            clken <= 1'b1;
            cnt   <= div;
          end else begin
            clken <= 1'b0;
            cnt   <= cnt - DIVW'(1);
          end
        end
        default: begin
          state <= IDLE;
          clken <= 1'b0;
        end
      endcase
    end
  end

endmodule

module perip_clken_sched #(
  parameter int DIVW = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            cfg_wr,
  input  logic [2:0]      cfg_addr,
  input  logic [DIVW-1:0] cfg_wdata,
  output logic [DIVW-1:0] cfg_rdata,
  output logic            dualtimer_clken1,
  output logic            dualtimer_clken2,
  output logic            watchdog_clken
);

  localparam logic [2:0] ADDR_CTRL    = 3'd3;
  localparam logic [2:0] ADDR_RESTART = 3'd4;

  logic [DIVW-1:0] div [3];
  logic [2:0]      en;
  logic [2:0]      clken;
  logic            ctrl_wr;
  logic            restart_wr;

  assign ctrl_wr    = cfg_wr && (cfg_addr == ADDR_CTRL);
  assign restart_wr = cfg_wr && (cfg_addr == ADDR_RESTART);

  for (genvar g = 0; g < 3; g++) begin : g_chan
    perip_clken_chan #(
      .DIVW (DIVW)
    ) u_chan (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .div_wr    (cfg_wr && (cfg_addr == 3'(g))),
      .div_wdata (cfg_wdata),
      .ctrl_wr   (ctrl_wr),
      .ctrl_bit  (cfg_wdata[g]),
      .restart   (restart_wr && cfg_wdata[g]),
      .div       (div[g]),
      .en        (en[g]),
      .clken     (clken[g])
    );
  end

  assign dualtimer_clken1 = clken[0];
  assign dualtimer_clken2 = clken[1];
  assign watchdog_clken   = clken[2];

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      3'd0:      cfg_rdata = div[0];
      3'd1:      cfg_rdata = div[1];
      3'd2:      cfg_rdata = div[2];
      ADDR_CTRL: cfg_rdata[2:0] = en;
      default:   cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_perip_clken_sched.sv
// Bench for perip_clken_sched: pulse-schedule reference model plus directed and random stimulus.
module tb_perip_clken_sched;

  logic        PCLK;
  logic        PRESETn;
  logic        cfg_wr;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic        dualtimer_clken1;
  logic        dualtimer_clken2;
  logic        watchdog_clken;

  perip_clken_sched #(.DIVW(16)) dut (
    .PCLK             (PCLK),
    .PRESETn          (PRESETn),
    .cfg_wr           (cfg_wr),
    .cfg_addr         (cfg_addr),
    .cfg_wdata        (cfg_wdata),
    .cfg_rdata        (cfg_rdata),
    .dualtimer_clken1 (dualtimer_clken1),
    .dualtimer_clken2 (dualtimer_clken2),
    .watchdog_clken   (watchdog_clken)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int compared   = 0;
  int mismatched = 0;
  bit chk_on     = 0;

  // Reference model: per channel, the edge number of the next strobe.
  int          edge_n    = 0;
  bit          m_en  [3] = '{0, 0, 0};
  logic [15:0] m_div [3] = '{16'd0, 16'd0, 16'd0};
  longint      m_nxt [3] = '{0, 0, 0};
  bit          m_exp [3] = '{0, 0, 0};
  bit          step;

  function automatic logic [15:0] model_rd(input logic [2:0] a);
    case (a)
      3'd0:    return m_div[0];
      3'd1:    return m_div[1];
      3'd2:    return m_div[2];
      3'd3:    return {13'd0, m_en[2], m_en[1], m_en[0]};
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge PRESETn) begin
    for (int i = 0; i < 3; i++) begin
      m_en[i]  = 0;
      m_div[i] = 16'd0;
      m_exp[i] = 0;
    end
  end

  always @(posedge PCLK) begin
    edge_n++;
    if (PRESETn) begin
      for (int i = 0; i < 3; i++) begin
        step = m_en[i];
        if (cfg_wr && cfg_addr == 3'd3) begin
          if (!m_en[i] && cfg_wdata[i]) begin
            m_en[i]  = 1;
            m_nxt[i] = edge_n + m_div[i] + 1;
            m_exp[i] = 0;
            step     = 0;
          end else if (m_en[i] && !cfg_wdata[i]) begin
            m_en[i]  = 0;
            m_exp[i] = 0;
            step     = 0;
          end
        end
        if (cfg_wr && cfg_addr == 3'd4 && m_en[i] && cfg_wdata[i]) begin
          m_nxt[i] = edge_n + m_div[i] + 1;
          m_exp[i] = 0;
          step     = 0;
        end
        if (step) begin
          if (edge_n == m_nxt[i]) begin
            m_exp[i] = 1;
            m_nxt[i] = edge_n + m_div[i] + 1;
          end else begin
            m_exp[i] = 0;
          end
        end else if (!m_en[i]) begin
          m_exp[i] = 0;
        end
      end
      if (cfg_wr && cfg_addr < 3'd3) m_div[cfg_addr] = cfg_wdata;
    end
  end

  always @(negedge PCLK) begin
    if (chk_on) begin
      chk("model_clken1", dualtimer_clken1, m_exp[0]);
      chk("model_clken2", dualtimer_clken2, m_exp[1]);
      chk("model_wd_clken", watchdog_clken, m_exp[2]);
      chk("model_rdata", cfg_rdata, model_rd(cfg_addr));
    end
  end

  task automatic idle(input int k);
    repeat (k) @(posedge PCLK);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cfg_wr    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    @(posedge PCLK);
    #2;
    cfg_wr = 1'b0;
  endtask

  logic [31:0] rnd;

  initial begin
    PRESETn   = 1'b0;
    cfg_wr    = 1'b0;
    cfg_addr  = 3'd0;
    cfg_wdata = 16'd0;
    for (int a = 0; a < 8; a++) begin
      cfg_addr = 3'(a);
      #1;
      chk("rst_rdata", cfg_rdata, 32'd0);
    end
    #14 PRESETn = 1'b1;
    idle(1);
    chk_on = 1;

    // Idle after reset: every address reads 0, no strobes for 20 cycles.
    for (int a = 0; a < 8; a++) begin
      cfg_addr = 3'(a);
      idle(1);
      chk("post_rst_rdata", cfg_rdata, 32'd0);
    end
    for (int k = 0; k < 20; k++) begin
      idle(1);
      chk("idle_clkens", {dualtimer_clken1, dualtimer_clken2, watchdog_clken}, 32'd0);
    end

    // div=0: continuous strobe.
    wr(3'd0, 16'd0);
    wr(3'd3, 16'd1);
    chk("div0_first_edge", dualtimer_clken1, 32'd0);
    for (int k = 0; k < 6; k++) begin
      idle(1);
      chk("div0_high", dualtimer_clken1, 32'd1);
      chk("div0_others", {dualtimer_clken2, watchdog_clken}, 32'd0);
    end
    wr(3'd3, 16'd0);
    chk("div0_off", dualtimer_clken1, 32'd0);

    // div=3: one strobe every 4 cycles, first after E0+4.
    wr(3'd1, 16'd3);
    wr(3'd3, 16'd2);
    for (int k = 1; k <= 40; k++) begin
      idle(1);
      chk("div3_period", dualtimer_clken2, 32'((k % 4) == 0));
    end
    wr(3'd3, 16'd0);

    // Divisor change mid-period takes effect at the next reload.
    wr(3'd2, 16'd2);
    wr(3'd3, 16'd4);
    idle(3);
    chk("wd_first_pulse", watchdog_clken, 32'd1);
    wr(3'd2, 16'd5);
    chk("wd_mid_period", watchdog_clken, 32'd0);
    cfg_addr = 3'd2;
    #1 chk("wd_div_readback", cfg_rdata, 32'd5);
    idle(2);
    chk("wd_old_period_end", watchdog_clken, 32'd1);
    for (int k = 1; k <= 18; k++) begin
      idle(1);
      chk("wd_new_period", watchdog_clken, 32'((k % 6) == 0));
    end
    wr(3'd3, 16'd0);

    // Restart aligns two channels.
    wr(3'd0, 16'd1);
    wr(3'd1, 16'd3);
    wr(3'd3, 16'd3);
    idle(3);
    wr(3'd4, 16'd3);
    chk("restart_rdata", cfg_rdata, 32'd0);
    for (int k = 1; k <= 12; k++) begin
      idle(1);
      chk("restart_ch1", dualtimer_clken1, 32'((k % 2) == 0));
      chk("restart_ch2", dualtimer_clken2, 32'((k % 4) == 0));
      chk("restart_wd_off", watchdog_clken, 32'd0);
    end
    wr(3'd3, 16'd0);

    // Disable on the strobe cycle, then asynchronous reset mid-period.
    wr(3'd2, 16'd7);
    wr(3'd3, 16'd4);
    idle(7);
    chk("wd7_before", watchdog_clken, 32'd0);
    idle(1);
    chk("wd7_pulse", watchdog_clken, 32'd1);
    wr(3'd3, 16'd0);
    chk("wd7_disabled", watchdog_clken, 32'd0);
    wr(3'd0, 16'd0);
    wr(3'd3, 16'd5);
    idle(3);
    chk("pre_rst_clken1", dualtimer_clken1, 32'd1);
    #1 PRESETn = 1'b0;
    #1;
    chk("async_rst_outs", {dualtimer_clken1, dualtimer_clken2, watchdog_clken}, 32'd0);
    #12 PRESETn = 1'b1;
    idle(1);
    cfg_addr = 3'd3;
    #1 chk("ctrl_after_rst", cfg_rdata, 32'd0);
    idle(10);

    // Random traffic against the model, with one async reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        #1 PRESETn = 1'b0;
        #7 PRESETn = 1'b1;
        idle(1);
      end
      rnd = $urandom;
      cfg_addr = rnd[2:0];
      if ($urandom_range(0, 9) < 3) begin
        cfg_wr    = 1'b1;
        cfg_wdata = rnd[31:16];
        if (rnd[2:0] < 3'd3) cfg_wdata = 16'($urandom_range(0, 9));
      end else begin
        cfg_wr = 1'b0;
      end
      idle(1);
    end
    cfg_wr = 1'b0;
    idle(2);
    chk_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
